// File: rtl/uart_mem_pkg.sv
// Shared encodings for the UART host memory-access controller.
package uart_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STALL     = 3'd1,
        ST_ACCESS    = 3'd2,
        ST_READ_WAIT = 3'd3,
        ST_TX_SEND   = 3'd4,
        ST_TX_WAIT   = 3'd5,
        ST_RELEASE   = 3'd6
    } state_e;

    localparam logic MEM_IMEM = 1'b0;
    localparam logic MEM_DMEM = 1'b1;
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int DRAIN_CNT_BITS = 4;

endpackage

// File: rtl/uart_cmd_slot.sv
// Single-entry pending-command register; a load while full (and not being
// consumed in the same cycle) is dropped and flagged on drop_o.
module uart_cmd_slot #(
    parameter int CMD_W = 43
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             consume_i,
    input  logic [CMD_W-1:0] cmd_i,
    output logic             full_o,
    output logic [CMD_W-1:0] cmd_o,
    output logic             drop_o
);

    logic             full_q, full_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;

    // Next-state for the slot: consume frees it, a load refills it in the same cycle.
    always_comb begin
        full_d = full_q;
        cmd_d  = cmd_q;
        drop_o = 1'b0;
        if (consume_i) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
        if (load_i) begin
            if (full_q && !consume_i) begin
                drop_o = 1'b1;
            end else begin
                cmd_d  = cmd_i;
                full_d = 1'b1;
            end
        end else begin
            drop_o = 1'b0;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            cmd_q  <= {CMD_W{1'b0}};
        end else begin
            full_q <= full_d;
            cmd_q  <= cmd_d;
        end
    end

    assign full_o = full_q;
    assign cmd_o  = cmd_q;

endmodule

// File: rtl/uart_mem_ctrl.sv
// Host-access controller: stalls/drains the CPU, performs one memory word
// access per host command and returns read data through the UART transmitter.
module uart_mem_ctrl
    import uart_mem_pkg::*;
#(
    parameter int ADDR_BITS     = 9,
    parameter int DATA_WIDTH    = 32,
    parameter int DRAIN_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    input  logic                  cmd_rw,
    input  logic                  cmd_mem_type,
    input  logic [ADDR_BITS-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  cpu_stall,
    input  logic                  cpu_idle,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic                  mem_sel,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_done,
    output logic                  busy,
    output logic                  overflow,
    output logic                  timeout
);

    localparam int CMD_W = 2 + ADDR_BITS + DATA_WIDTH;
    localparam logic [DRAIN_CNT_BITS-1:0] DRAIN_LAST = DRAIN_CNT_BITS'(DRAIN_TIMEOUT - 1);

    state_e                    state_q, state_d;
    logic [DRAIN_CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CMD_W-1:0]          act_q, act_d;
    logic [DATA_WIDTH-1:0]     tx_data_q, tx_data_d;
    logic                      timeout_q, timeout_d;
    logic                      overflow_q, overflow_d;

    logic                      slot_load_s;
    logic                      slot_consume_s;
    logic                      slot_full_s;
    logic                      slot_drop_s;
    logic [CMD_W-1:0]          slot_cmd_s;
    logic [CMD_W-1:0]          cmd_in_s;

    // Command word layout: {rw, mem_type, addr, wdata}
    assign cmd_in_s = {cmd_rw, cmd_mem_type, cmd_addr, cmd_wdata};

    uart_cmd_slot #(.CMD_W(CMD_W)) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (slot_load_s),
        .consume_i (slot_consume_s),
        .cmd_i     (cmd_in_s),
        .full_o    (slot_full_s),
        .cmd_o     (slot_cmd_s),
        .drop_o    (slot_drop_s)
    );

    // FSM next-state, drain counter, active command and captured read data.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        act_d          = act_q;
        tx_data_d      = tx_data_q;
        timeout_d      = timeout_q;
        overflow_d     = overflow_q | slot_drop_s;
        slot_load_s    = cmd_valid && (state_q != ST_IDLE);
        slot_consume_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    act_d   = cmd_in_s;
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (cpu_idle) begin
                    cnt_d   = {DRAIN_CNT_BITS{1'b0}};
                    state_d = ST_ACCESS;
                end else if (cnt_q == DRAIN_LAST) begin
                    cnt_d     = {DRAIN_CNT_BITS{1'b0}};
                    timeout_d = 1'b1;
                    state_d   = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q + DRAIN_CNT_BITS'(1);
                end
            end
            ST_ACCESS: begin
                if (act_q[CMD_W-1] == RW_WRITE) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_READ_WAIT;
                end
            end
            ST_READ_WAIT: begin
                tx_data_d = mem_rdata;
                state_d   = ST_TX_SEND;
            end
            ST_TX_SEND: begin
                state_d = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (tx_done) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_TX_WAIT;
                end
            end
            ST_RELEASE: begin
                if (slot_full_s) begin
                    act_d          = slot_cmd_s;
                    slot_consume_s = 1'b1;
                    state_d        = ST_STALL;
                end else if (cmd_valid) begin
                    // Take a command arriving with the slot empty straight into
                    // the active register so IDLE is never entered with the slot full.
                    slot_load_s = 1'b0;
                    act_d       = cmd_in_s;
                    state_d     = ST_STALL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {DRAIN_CNT_BITS{1'b0}};
            act_q      <= {CMD_W{1'b0}};
            tx_data_q  <= {DATA_WIDTH{1'b0}};
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_q      <= act_d;
            tx_data_q  <= tx_data_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    assign cpu_stall = (state_q != ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_we    = (state_q == ST_ACCESS) && (act_q[CMD_W-1] == RW_WRITE);
    assign mem_sel   = act_q[CMD_W-2];
    assign mem_addr  = act_q[DATA_WIDTH +: ADDR_BITS];
    assign mem_wdata = act_q[DATA_WIDTH-1:0];
    assign tx_start  = (state_q == ST_TX_SEND);
    assign tx_data   = tx_data_q;
    assign overflow  = overflow_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// Directed self-checking bench for uart_mem_ctrl.
module tb_uart_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_rw;
    logic        cmd_mem_type;
    logic [8:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cpu_stall;
    logic        cpu_idle;
    logic        mem_en;
    logic        mem_we;
    logic        mem_sel;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        tx_start;
    logic [31:0] tx_data;
    logic        tx_done;
    logic        busy;
    logic        overflow;
    logic        timeout;

    logic [31:0] rd_value;
    int          en_count = 0;
    int          tx_count = 0;
    int          n_assert = 0;
    int          n_fail   = 0;
    int          en_base;
    int          tx_base;
    int          stall_cycles;

    uart_mem_ctrl #(.ADDR_BITS(9), .DATA_WIDTH(32), .DRAIN_TIMEOUT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_rw       (cmd_rw),
        .cmd_mem_type (cmd_mem_type),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cpu_stall    (cpu_stall),
        .cpu_idle     (cpu_idle),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done      (tx_done),
        .busy         (busy),
        .overflow     (overflow),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Memory read model and strobe counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= rd_value;
        if (rst_n && mem_en) en_count <= en_count + 1;
        if (rst_n && tx_start) tx_count <= tx_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic rw, input logic mt, input logic [8:0] a, input logic [31:0] d);
        cmd_valid    = 1'b1;
        cmd_rw       = rw;
        cmd_mem_type = mt;
        cmd_addr     = a;
        cmd_wdata    = d;
        tick();
        cmd_valid    = 1'b0;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_stall"}, cpu_stall, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_mem_en"}, mem_en, 1'b0);
        chk1({tag, "_mem_we"}, mem_we, 1'b0);
        chk1({tag, "_mem_sel"}, mem_sel, 1'b0);
        chk32({tag, "_mem_addr"}, {23'd0, mem_addr}, 32'h0);
        chk32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk1({tag, "_tx_start"}, tx_start, 1'b0);
        chk32({tag, "_tx_data"}, tx_data, 32'h0);
        chk1({tag, "_overflow"}, overflow, 1'b0);
        chk1({tag, "_timeout"}, timeout, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_mem_type = 1'b0;
        cmd_addr = 9'd0; cmd_wdata = 32'd0; cpu_idle = 1'b1; tx_done = 1'b0;
        rd_value = 32'd0;
        repeat (2) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Write DMEM 0x005
        en_base = en_count;
        send_cmd(1'b1, 1'b1, 9'h005, 32'hDEADBEEF);
        chk1("wr_stall_n1", cpu_stall, 1'b1);
        chk1("wr_busy_n1", busy, 1'b1);
        chk1("wr_no_en_n1", mem_en, 1'b0);
        tick();
        chk1("wr_mem_en", mem_en, 1'b1);
        chk1("wr_mem_we", mem_we, 1'b1);
        chk1("wr_mem_sel", mem_sel, 1'b1);
        chk32("wr_mem_addr", {23'd0, mem_addr}, 32'h005);
        chk32("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        chk1("wr_release_en", mem_en, 1'b0);
        chk1("wr_release_stall", cpu_stall, 1'b1);
        tick();
        chk1("wr_stall_low_n4", cpu_stall, 1'b0);
        chk1("wr_busy_low_n4", busy, 1'b0);
        chk_int("wr_en_count", en_count - en_base, 1);

        // Read IMEM 0x1FF
        tx_base  = tx_count;
        rd_value = 32'h12345678;
        send_cmd(1'b0, 1'b0, 9'h1FF, 32'h0);
        tick();
        chk1("rd_mem_en", mem_en, 1'b1);
        chk1("rd_mem_we", mem_we, 1'b0);
        chk1("rd_mem_sel", mem_sel, 1'b0);
        chk32("rd_mem_addr", {23'd0, mem_addr}, 32'h1FF);
        tick();
        chk1("rd_wait_no_start", tx_start, 1'b0);
        tick();
        chk1("rd_tx_start", tx_start, 1'b1);
        chk32("rd_tx_data", tx_data, 32'h12345678);
        tick();
        chk1("rd_tx_start_single", tx_start, 1'b0);
        repeat (3) tick();
        chk1("rd_stall_in_txwait", cpu_stall, 1'b1);
        chk32("rd_tx_data_held", tx_data, 32'h12345678);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk1("rd_release_stall", cpu_stall, 1'b1);
        tick();
        chk1("rd_stall_low", cpu_stall, 1'b0);
        chk_int("rd_tx_count", tx_count - tx_base, 1);

        // Drain timeout with cpu_idle low
        cpu_idle = 1'b0;
        send_cmd(1'b1, 1'b0, 9'h0AA, 32'h00000055);
        stall_cycles = 0;
        while (!mem_en && stall_cycles < 40) begin
            stall_cycles++;
            tick();
        end
        chk_int("to_stall_cycles", stall_cycles, 15);
        chk1("to_mem_en", mem_en, 1'b1);
        chk1("to_timeout_set", timeout, 1'b1);
        cpu_idle = 1'b1;
        repeat (2) tick();
        chk1("to_idle_stall", cpu_stall, 1'b0);
        chk1("to_timeout_sticky", timeout, 1'b1);

        // Three commands: read plus two arriving in TX_WAIT
        en_base  = en_count;
        rd_value = 32'hA5A5A5A5;
        send_cmd(1'b0, 1'b1, 9'h010, 32'h0);
        repeat (4) tick();
        send_cmd(1'b1, 1'b0, 9'h020, 32'h11111111);
        chk1("ov_no_overflow_yet", overflow, 1'b0);
        send_cmd(1'b1, 1'b0, 9'h030, 32'h22222222);
        chk1("ov_overflow_set", overflow, 1'b1);
        chk32("ov_tx_data", tx_data, 32'hA5A5A5A5);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk1("ov_release_stall", cpu_stall, 1'b1);
        tick();
        chk1("ov_no_gap_stall", cpu_stall, 1'b1);
        chk1("ov_no_gap_busy", busy, 1'b1);
        tick();
        chk1("ov_2nd_en", mem_en, 1'b1);
        chk1("ov_2nd_we", mem_we, 1'b1);
        chk32("ov_2nd_addr", {23'd0, mem_addr}, 32'h020);
        chk32("ov_2nd_wdata", mem_wdata, 32'h11111111);
        repeat (2) tick();
        chk1("ov_idle_stall", cpu_stall, 1'b0);
        repeat (3) tick();
        chk_int("ov_en_count", en_count - en_base, 2);
        chk1("ov_overflow_sticky", overflow, 1'b1);

        // Asynchronous reset in TX_WAIT
        rd_value = 32'h0BADF00D;
        send_cmd(1'b0, 1'b1, 9'h033, 32'h0);
        repeat (4) tick();
        chk1("rst_pre_stall", cpu_stall, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        tick();
        rst_n   = 1'b1;
        tx_base = tx_count;
        en_base = en_count;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk1("rst_done_ignored_busy", busy, 1'b0);
        chk1("rst_done_ignored_stall", cpu_stall, 1'b0);
        tick();
        chk1("rst_still_idle", busy, 1'b0);
        chk_int("rst_no_tx_start", tx_count - tx_base, 0);
        send_cmd(1'b1, 1'b1, 9'h100, 32'hCAFEF00D);
        tick();
        chk1("rst_new_en", mem_en, 1'b1);
        chk32("rst_new_addr", {23'd0, mem_addr}, 32'h100);
        chk32("rst_new_wdata", mem_wdata, 32'hCAFEF00D);
        repeat (2) tick();
        chk1("rst_new_done", cpu_stall, 1'b0);
        chk_int("rst_en_count", en_count - en_base, 1);

        // cmd_valid in RELEASE with slot full
        en_base  = en_count;
        rd_value = 32'h0F0F0F0F;
        send_cmd(1'b0, 1'b0, 9'h001, 32'h0);
        repeat (4) tick();
        send_cmd(1'b1, 1'b1, 9'h040, 32'h33333333);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        send_cmd(1'b1, 1'b1, 9'h050, 32'h44444444);
        chk1("rl_stall_a", cpu_stall, 1'b1);
        tick();
        chk1("rl_p_en", mem_en, 1'b1);
        chk32("rl_p_addr", {23'd0, mem_addr}, 32'h040);
        chk32("rl_p_wdata", mem_wdata, 32'h33333333);
        tick();
        tick();
        chk1("rl_stall_b", cpu_stall, 1'b1);
        tick();
        chk1("rl_n_en", mem_en, 1'b1);
        chk32("rl_n_addr", {23'd0, mem_addr}, 32'h050);
        chk32("rl_n_wdata", mem_wdata, 32'h44444444);
        repeat (2) tick();
        chk1("rl_idle_stall", cpu_stall, 1'b0);
        chk1("rl_overflow_clear", overflow, 1'b0);
        chk_int("rl_en_count", en_count - en_base, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
